// File: rtl/riscv_dcache_tag_nway.sv
// N-way set-associative tag/valid/dirty store for the data cache.
// It provides zero-latency lookup, a misaligned lookup of the next set, true-LRU
// replacement that picks invalid ways first, and a flush walker that issues
// dirty-line writebacks.
module riscv_dcache_tag_nway #(
    parameter int IDX  = 12,
    parameter int TAG  = 9,
    parameter int WAYS = 4,
    parameter int SETS = 4096,
    localparam int WW  = $clog2(WAYS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] index,
    input  logic [TAG-1:0] tag_in,
    input  logic           valid_in,
    input  logic           dirty_in,
    input  logic           access,
    input  logic           set_dirty,
    input  logic           replace_tag,
    output logic           hit,
    output logic [WW-1:0]  hit_way,
    output logic           dirty,
    output logic           hit_misaligned,
    output logic           dirty_misaligned,
    output logic [WW-1:0]  victim_way,
    output logic [TAG-1:0] tag_old,
    output logic           victim_dirty,
    input  logic           flush_req,
    output logic           flush_busy,
    output logic           flush_done,
    output logic           wb_valid,
    input  logic           wb_ready,
    output logic [IDX-1:0] wb_index,
    output logic [WW-1:0]  wb_way,
    output logic [TAG-1:0] wb_tag
);

    // Reset age row: way w starts with age w, so the victim of a full set is the last way.
    function automatic logic [WAYS-1:0][WW-1:0] age_row_init();
        logic [WAYS-1:0][WW-1:0] r;
        for (int w = 0; w < WAYS; w++) r[w] = WW'(w);
        return r;
    endfunction

    localparam logic [WAYS-1:0][WW-1:0] AGE_ROW = age_row_init();

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;

    state_t                             state_q, state_d;
    logic [IDX-1:0]                     fset_q, fset_d;
    logic [WW-1:0]                      fway_q, fway_d;
    logic [SETS-1:0][WAYS-1:0]          valid_q;
    logic [SETS-1:0][WAYS-1:0]          dirty_q;
    logic [SETS-1:0][WAYS-1:0][WW-1:0]  age_q;
    logic [TAG-1:0]                     tag_q [SETS][WAYS];

    logic [IDX-1:0]            index_p1;
    logic                      hit_raw, mis_raw, vic_found;
    logic [WW-1:0]             hit_way_raw, mis_way_raw, vic_way;
    logic                      touch_en;
    logic [WW-1:0]             touch_way;
    logic [WAYS-1:0][WW-1:0]   age_row_d;
    logic                      clr_v, clr_d, advance, last;

    // Misaligned accesses look at the following set; the index wraps naturally.
    assign index_p1 = index + IDX'(1);

    // Tag compare on both sets (lowest matching way wins) and victim selection.
    always_comb begin
        hit_raw     = 1'b0;
        hit_way_raw = '0;
        mis_raw     = 1'b0;
        mis_way_raw = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[index][w] && (tag_q[index][w] == tag_in)) begin
                hit_raw     = 1'b1;
                hit_way_raw = WW'(w);
            end
            if (valid_q[index_p1][w] && (tag_q[index_p1][w] == tag_in)) begin
                mis_raw     = 1'b1;
                mis_way_raw = WW'(w);
            end
        end
        vic_way   = '0;
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[index][w]) begin
                vic_found = 1'b1;
                vic_way   = WW'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[index][w] == WW'(WAYS - 1)) vic_way = WW'(w);
            end
        end
    end

    assign flush_busy       = (state_q == S_SCAN) || (state_q == S_WB);
    assign hit              = hit_raw & ~flush_busy;
    assign hit_way          = flush_busy ? '0 : hit_way_raw;
    assign dirty            = hit & dirty_q[index][hit_way_raw];
    assign hit_misaligned   = mis_raw & ~flush_busy;
    assign dirty_misaligned = hit_misaligned & dirty_q[index_p1][mis_way_raw];
    assign victim_way       = vic_way;
    assign tag_old          = tag_q[index][vic_way];
    assign victim_dirty     = valid_q[index][vic_way] & dirty_q[index][vic_way];
    assign wb_index         = fset_q;
    assign wb_way           = fway_q;
    assign wb_tag           = tag_q[fset_q][fway_q];

    // A replace touches the victim; otherwise a hitting access touches the hit way.
    assign touch_en  = replace_tag | (access & hit_raw);
    assign touch_way = replace_tag ? vic_way : hit_way_raw;

    // New age row for a touch: younger ways age by one, the touched way becomes MRU.
    always_comb begin
        age_row_d = age_q[index];
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[index][w] < age_q[index][touch_way]) age_row_d[w] = age_q[index][w] + WW'(1);
        end
        age_row_d[touch_way] = '0;
    end

    // Flush walker: next state, writeback handshake and line-clear strobes.
    always_comb begin
        state_d    = state_q;
        fset_d     = fset_q;
        fway_d     = fway_q;
        wb_valid   = 1'b0;
        flush_done = 1'b0;
        clr_v      = 1'b0;
        clr_d      = 1'b0;
        advance    = 1'b0;
        last       = (fset_q == IDX'(SETS - 1)) && (fway_q == WW'(WAYS - 1));
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_SCAN;
                    fset_d  = '0;
                    fway_d  = '0;
                end
            end
            S_SCAN: begin
                if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
                    state_d = S_WB;
                end else begin
                    clr_v   = 1'b1;
                    advance = 1'b1;
                end
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    clr_v   = 1'b1;
                    clr_d   = 1'b1;
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                flush_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (last) begin
                state_d = S_DONE;
            end else begin
                state_d = S_SCAN;
                if (fway_q == WW'(WAYS - 1)) begin
                    fway_d = '0;
                    fset_d = fset_q + IDX'(1);
                end else begin
                    fway_d = fway_q + WW'(1);
                end
            end
        end
    end

    // State, valid/dirty bits and LRU ages; lookups update only while the walker is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fset_q  <= '0;
            fway_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            age_q   <= {SETS{AGE_ROW}};
        end else begin
            state_q <= state_d;
            fset_q  <= fset_d;
            fway_q  <= fway_d;
            if (clr_v) valid_q[fset_q][fway_q] <= 1'b0;
            if (clr_d) dirty_q[fset_q][fway_q] <= 1'b0;
            if (!flush_busy) begin
                if (replace_tag) begin
                    valid_q[index][vic_way] <= valid_in;
                    dirty_q[index][vic_way] <= dirty_in;
                end else if (set_dirty && hit_raw) begin
                    dirty_q[index][hit_way_raw] <= 1'b1;
                end
                if (touch_en) age_q[index] <= age_row_d;
            end
        end
    end

    // Tag storage carries no reset; a tag only matters once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && !flush_busy && replace_tag) tag_q[index][vic_way] <= tag_in;
    end

endmodule

// File: tb/tb_riscv_dcache_tag_nway.sv
// Testbench for riscv_dcache_tag_nway: directed steps plus random traffic against
// a recency-list cache model.
module tb_riscv_dcache_tag_nway;
    localparam int IDX = 2, TAG = 9, WAYS = 4, SETS = 4, WW = 2;

    logic           clk = 1'b0;
    logic           rst, valid_in, dirty_in, access, set_dirty, replace_tag, flush_req, wb_ready;
    logic [IDX-1:0] index, wb_index;
    logic [TAG-1:0] tag_in, tag_old, wb_tag;
    logic           hit, dirty, hit_misaligned, dirty_misaligned, victim_dirty;
    logic           flush_busy, flush_done, wb_valid;
    logic [WW-1:0]  hit_way, victim_way, wb_way;

    int checks = 0;
    int failures = 0;

    // Model: valid/dirty/tag per line plus a per-set recency list (element 0 = most recent way).
    bit             mv  [SETS][WAYS];
    bit             md  [SETS][WAYS];
    logic [TAG-1:0] mt  [SETS][WAYS];
    int             ord [SETS][WAYS];

    always #5 clk = ~clk;

    riscv_dcache_tag_nway #(.IDX(IDX), .TAG(TAG), .WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst(rst), .index(index), .tag_in(tag_in), .valid_in(valid_in),
        .dirty_in(dirty_in), .access(access), .set_dirty(set_dirty), .replace_tag(replace_tag),
        .hit(hit), .hit_way(hit_way), .dirty(dirty), .hit_misaligned(hit_misaligned),
        .dirty_misaligned(dirty_misaligned), .victim_way(victim_way), .tag_old(tag_old),
        .victim_dirty(victim_dirty), .flush_req(flush_req), .flush_busy(flush_busy),
        .flush_done(flush_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index),
        .wb_way(wb_way), .wb_tag(wb_tag)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; ord[s][w] = w;
            end
    endfunction

    function automatic int m_victim(int s);
        for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
        return ord[s][WAYS-1];
    endfunction

    function automatic int m_find(int s, logic [TAG-1:0] t);
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) return w;
        return -1;
    endfunction

    function automatic void m_touch(int s, int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endfunction

    // Compare every lookup output against the model for the currently driven index/tag.
    task automatic check_lookup(input string nm);
        int s, s1, f, f1, v, fi, fi1;
        s = int'(index); s1 = (s + 1) % SETS;
        f = m_find(s, tag_in); f1 = m_find(s1, tag_in); v = m_victim(s);
        fi = (f < 0) ? 0 : f; fi1 = (f1 < 0) ? 0 : f1;
        chk({nm, ".hit"}, hit, f >= 0);
        chk({nm, ".hit_way"}, hit_way, fi);
        chk({nm, ".dirty"}, dirty, (f >= 0) && md[s][fi]);
        chk({nm, ".hit_mis"}, hit_misaligned, f1 >= 0);
        chk({nm, ".dirty_mis"}, dirty_misaligned, (f1 >= 0) && md[s1][fi1]);
        chk({nm, ".victim_way"}, victim_way, v);
        chk({nm, ".victim_dirty"}, victim_dirty, mv[s][v] && md[s][v]);
        if (mv[s][v]) chk({nm, ".tag_old"}, tag_old, mt[s][v]);
    endtask

    task automatic do_reset();
        rst = 1; flush_req = 0; access = 0; set_dirty = 0; replace_tag = 0;
        wb_ready = 0; valid_in = 0; dirty_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_reset();
    endtask

    // One cycle of lookup/update traffic: check outputs, then commit to DUT and model.
    task automatic op(input int s, input logic [TAG-1:0] t, input bit acc, input bit sd,
                      input bit rep, input bit vin, input bit din);
        index = IDX'(s); tag_in = t; access = acc; set_dirty = sd; replace_tag = rep;
        valid_in = vin; dirty_in = din;
        #1 check_lookup("op");
        if (rep) begin
            int v;
            v = m_victim(s);
            mv[s][v] = vin; md[s][v] = din; mt[s][v] = t; m_touch(s, v);
        end else begin
            int f;
            f = m_find(s, t);
            if (f >= 0 && acc) m_touch(s, f);
            if (f >= 0 && sd) md[s][f] = 1;
        end
        @(posedge clk);
        #1 access = 0; set_dirty = 0; replace_tag = 0; valid_in = 0; dirty_in = 0;
    endtask

    // Run a full flush; the bench chooses how long to hold off each writeback.
    task automatic do_flush(input bit rnd, input int hidx, input logic [TAG-1:0] htag);
        int es[$], ew[$], waits[$];
        logic [TAG-1:0] et[$];
        int exp_done, c, k, wc;
        bit done_seen;
        exp_done = SETS * WAYS + 1;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (mv[s][w] && md[s][w]) begin
                    int wt;
                    wt = rnd ? int'($urandom_range(0, 3)) : 3;
                    es.push_back(s); ew.push_back(w); et.push_back(mt[s][w]); waits.push_back(wt);
                    exp_done += wt + 1;
                end
        flush_req = 1; index = IDX'(hidx); tag_in = htag;
        @(posedge clk);
        #1 flush_req = 0;
        c = 1; k = 0; wc = 0; done_seen = 0;
        while (!done_seen && c <= SETS * WAYS * 6 + 10) begin
            if (flush_done) begin
                done_seen = 1;
                chk("flush_done_cycle", c, exp_done);
                chk("busy_in_done", flush_busy, 0);
                replace_tag = 0; wb_ready = 0;
            end else begin
                chk("flush_busy", flush_busy, 1);
                chk("hit_during_busy", hit, 0);
                chk("hit_mis_during_busy", hit_misaligned, 0);
                replace_tag = 1; valid_in = 1; dirty_in = 1;
                if (wb_valid) begin
                    if (k < es.size()) begin
                        chk("wb_index", wb_index, es[k]);
                        chk("wb_way", wb_way, ew[k]);
                        chk("wb_tag", wb_tag, et[k]);
                        if (wc == waits[k]) begin wb_ready = 1; k++; wc = 0; end
                        else begin wb_ready = 0; wc++; end
                    end else begin
                        chk("wb_unexpected", wb_valid, 0);
                        wb_ready = 1;
                    end
                end else begin
                    wb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
            @(posedge clk);
            #1 c++;
        end
        chk("flush_completed", done_seen, 1);
        chk("wb_count", k, es.size());
        chk("done_single_pulse", flush_done, 0);
        replace_tag = 0; wb_ready = 0; valid_in = 0; dirty_in = 0;
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
        for (int i = 0; i < es.size(); i++) md[es[i]][ew[i]] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAG-1:0] fill_t [4];
        int c;
        fill_t = '{9'h11, 9'h22, 9'h33, 9'h44};
        index = '0; tag_in = '0;
        do_reset();
        chk("rst_hit", hit, 0);
        chk("rst_victim_way", victim_way, 0);
        chk("rst_victim_dirty", victim_dirty, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_flush_done", flush_done, 0);

        // Fill set 1: victims go 0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            index = 1; #1 chk("fill_victim", victim_way, i);
            op(1, fill_t[i], 0, 0, 1, 1, 0);
        end
        index = 1; tag_in = 9'h33;
        #1 chk("hit_0x33", hit, 1);
        chk("hit_way_0x33", hit_way, 2);

        // Access 0x11 makes way 1 (0x22) the LRU victim.
        op(1, 9'h11, 1, 0, 0, 0, 0);
        index = 1; #1 chk("lru_victim", victim_way, 1);
        chk("lru_tag_old", tag_old, 9'h22);
        op(1, 9'h55, 0, 0, 1, 1, 0);
        index = 1; tag_in = 9'h22; #1 chk("evicted_0x22", hit, 0);
        tag_in = 9'h11; #1 chk("kept_0x11", hit, 1);

        // Store-hit dirty marking, miss ignored, replace wins over access/set_dirty.
        op(1, 9'h33, 0, 1, 0, 0, 0);
        index = 1; tag_in = 9'h33; #1 chk("set_dirty_hit", dirty, 1);
        op(1, 9'h77, 0, 1, 0, 0, 0);
        op(1, 9'h44, 1, 1, 1, 1, 0);
        index = 1; tag_in = 9'h44;
        #1 chk("replace_only_victim", victim_way, 3);
        chk("replace_only_hit_way", hit_way, 2);
        chk("replace_only_dirty", dirty, 0);
        check_lookup("after_replace");

        // Misaligned compare wraps from the last set to set 0.
        op(0, 9'h44, 0, 0, 1, 1, 1);
        index = 3; tag_in = 9'h44;
        #1 chk("mis_wrap_hit", hit_misaligned, 1);
        chk("mis_wrap_dirty", dirty_misaligned, 1);
        check_lookup("mis_wrap");

        // Flush with two dirty lines at (0,2) and (3,1), writebacks held off 3 cycles each.
        do_reset();
        op(0, 9'h100, 0, 0, 1, 1, 0);
        op(0, 9'h101, 0, 0, 1, 1, 0);
        op(0, 9'h102, 0, 0, 1, 1, 1);
        op(3, 9'h130, 0, 0, 1, 1, 0);
        op(3, 9'h131, 0, 0, 1, 1, 1);
        do_flush(0, 3, 9'h130);
        for (int s = 0; s < SETS; s++) begin
            index = IDX'(s); tag_in = (s == 0) ? 9'h102 : 9'h131;
            #1 chk("post_flush_victim", victim_way, 0);
            check_lookup("post_flush");
        end

        // Reset while a writeback is pending.
        do_reset();
        op(2, 9'h1AA, 0, 0, 1, 1, 1);
        flush_req = 1; @(posedge clk); #1 flush_req = 0; wb_ready = 0;
        c = 0;
        while (!wb_valid && c < 40) begin @(posedge clk); #1 c++; end
        chk("wb_valid_before_rst", wb_valid, 1);
        rst = 1; @(posedge clk); #1 rst = 0; m_reset();
        index = 2; tag_in = 9'h1AA;
        #1 chk("rst_mid_busy", flush_busy, 0);
        chk("rst_mid_wb_valid", wb_valid, 0);
        chk("rst_mid_hit", hit, 0);
        chk("rst_mid_victim", victim_way, 0);
        check_lookup("rst_mid");
        @(posedge clk); #1 chk("rst_wb_dropped", wb_valid, 0);
        chk("rst_stays_idle", flush_busy, 0);

        // Random traffic, a random-handshake flush, then more traffic.
        do_reset();
        for (int i = 0; i < 300; i++)
            op(int'($urandom_range(0, SETS - 1)), TAG'(9'h100 + $urandom_range(0, 5)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
        do_flush(1, int'($urandom_range(0, SETS - 1)), TAG'(9'h100 + $urandom_range(0, 5)));
        for (int s = 0; s < SETS; s++) begin
            index = IDX'(s); tag_in = TAG'(9'h100 + $urandom_range(0, 5));
            #1 check_lookup("rand_post_flush");
        end
        for (int i = 0; i < 60; i++)
            op(int'($urandom_range(0, SETS - 1)), TAG'(9'h100 + $urandom_range(0, 5)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
               1'b1, 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_dcache_tag_nway.md
Name: riscv_dcache_tag_nway

Overview:
- N-way set-associative tag/valid/dirty store for the data cache.
- Successor to the direct-mapped tag array.
- Adds WAYS-way associativity, per-set true-LRU replacement with invalid-first victim selection, store-hit dirty marking, and a flush walker that emits dirty-line writeback requests over a valid/ready handshake.
- Sits between the dcache controller FSM and the data array; the data array is indexed by {index, way}.

Parameters:
- IDX, 12, set index width.
- TAG, 9, tag width.
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 4096, number of sets; equals 2**IDX.
- WW, $clog2(WAYS), way-select width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- index  in  IDX  lookup/update set.
- tag_in  in  TAG  lookup/compare tag; tag written on replace.
- valid_in  in  1  valid bit written on replace.
- dirty_in  in  1  dirty bit written on replace.
- access  in  1  on hit: make hit way MRU.
- set_dirty  in  1  on hit: set dirty of hit way.
- replace_tag  in  1  write {valid_in, tag_in, dirty_in} into victim_way of index; make it MRU.
- hit  out  1  some valid way of index matches tag_in.
- hit_way  out  WW  matching way (lowest index if several); 0 on miss.
- dirty  out  1  dirty bit of hit way; 0 on miss.
- hit_misaligned  out  1  same compare on set (index+1) mod SETS.
- dirty_misaligned  out  1  dirty of the matching way in set index+1; 0 on miss.
- victim_way  out  WW  way a replace_tag would write.
- tag_old  out  TAG  tag stored in victim_way (writeback address).
- victim_dirty  out  1  valid&dirty of victim_way.
- flush_req  in  1  start flush (pulse; ignored while busy).
- flush_busy  out  1  flush walker active.
- flush_done  out  1  one-cycle pulse on completion.
- wb_valid  out  1  writeback request pending.
- wb_ready  in  1  controller accepts writeback.
- wb_index  out  IDX  set of line being written back.
- wb_way  out  WW  way of line being written back.
- wb_tag  out  TAG  tag of line being written back.

Behaviour:
- Lookup outputs are combinational from index/tag_in and current state; zero latency. Updates are visible the cycle after the rising edge.
- Reset (sync): all valid=0, dirty=0. LRU age[w]=w in every set. FSM=IDLE. flush_busy, flush_done, wb_valid=0. Tags are don't-care.
- After reset: hit=0, victim_way=0, victim_dirty=0.
- LRU: per set, WW-bit age per way, always a permutation of 0..WAYS-1 (0 = MRU).
  - Touching way w: every way with age < age[w] increments; age[w] becomes 0.
- Victim: lowest-index invalid way if any, else the way with age WAYS-1.
- access & hit → touch hit_way. access & miss → no change.
- set_dirty & hit → dirty[hit_way]=1. set_dirty & miss → ignored.
- replace_tag → write victim_way and touch it. This wins over access/set_dirty in the same cycle.
- Misaligned compare wraps: index SETS-1 checks set 0 with the same tag_in. Tag carry is the caller's responsibility.
- During flush_busy:
  - hit, hit_misaligned forced 0.
  - access, set_dirty, replace_tag ignored.
- Flush FSM:
  - IDLE: on flush_req go to SCAN with set=0, way=0, flush_busy=1.
  - SCAN: examine (set, way) in one cycle.
    - If valid&dirty: go to WB.
    - Else: clear valid, advance.
  - WB: wb_valid=1 with wb_index/wb_way/wb_tag held stable until wb_ready. On wb_valid&wb_ready: clear valid and dirty, advance, return to SCAN.
  - Advance order: way++; after WAYS-1, way=0 and set++. After the last (SETS-1, WAYS-1): go to DONE.
  - DONE: flush_done=1 for one cycle, flush_busy=0, then IDLE. LRU ages are untouched by flush.
- Clean-cache flush takes SETS*WAYS SCAN cycles + 1 DONE cycle.
- wb_ready without wb_valid is ignored.
- rst at any point, including mid-flush or with wb_valid high: next cycle is fully reset state. The pending writeback is dropped.

Test Plan:
- IDX=2, WAYS=4. Reset, then replace_tag tags 0x11, 0x22, 0x33, 0x44 into set 1. Required: victim_way 0,1,2,3 in turn; afterwards hit with hit_way=2 for tag 0x33.
- Same set, access on tag 0x11, then replace_tag tag 0x55. Required: victim_way=1, tag_old=0x22; afterwards 0x22 misses and 0x11 hits.
- set_dirty on hit of tag 0x33. Required: dirty=1. set_dirty on miss of tag 0x77: no state change. replace_tag+access same cycle: only the replace takes effect.
- index=3 (SETS-1) with tag 0x44 in set 0. Required: hit_misaligned=1, dirty_misaligned equals set 0's bit.
- Two dirty lines (set 0 way 2, set 3 way 1), then flush_req with wb_ready low for 3 cycles. Required:
  - wb_valid held with {0, 2, tag} stable, then {3, 1, tag}.
  - flush_done once after SETS*WAYS+2 handshake cycles.
  - All lines invalid afterwards; hit=0 during busy.
- rst asserted while wb_valid=1. Required: next cycle flush_busy=0, wb_valid=0, all hits 0, victim_way=0.
